// File: rtl/sram_access_master_if.sv
// Core-side command/response channels and h-side transfer bus of sram_access_master.
// The master modport is the block's view; slave is the view of its surroundings.
interface sram_access_master_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WORD_WIDTH = 8
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [WORD_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [WORD_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic                  hwrite;
  logic [WORD_WIDTH-1:0] hwdata;
  logic                  hready;
  logic [WORD_WIDTH-1:0] hrdata;

  logic                  busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, hready, hrdata,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
    output hsel, haddr, hwrite, hwdata, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, hready, hrdata,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
    input  hsel, haddr, hwrite, hwdata, busy
  );
endinterface

// File: rtl/sram_access_master.sv
// Buffers core read/write commands in a FIFO and issues them one at a time on the h-side bus,
// returning one response per command; a watchdog turns a stuck hready handshake into an error.
module sram_access_master #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic                  hclk,
  input logic                  hresetn,
  sram_access_master_if.master bus
);
  localparam int unsigned PtrWidth = $clog2(FIFO_DEPTH);
  localparam int unsigned CntWidth = PtrWidth + 1;
  localparam int unsigned TmrWidth = $clog2(TIMEOUT + 1);
  localparam int unsigned EntWidth = 1 + ADDR_WIDTH + WORD_WIDTH;

  localparam logic [CntWidth-1:0] CntFull  = CntWidth'(FIFO_DEPTH);
  localparam logic [TmrWidth-1:0] TmrLimit = TmrWidth'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitLo,
    StWaitHi,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [TmrWidth-1:0]   timer_q, timer_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
  logic [EntWidth-1:0]   fifo_mem [FIFO_DEPTH];

  logic                  hwrite_q;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic [WORD_WIDTH-1:0] hwdata_q;

  logic                  rsp_valid_q;
  logic                  rsp_write_q;
  logic [WORD_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_load;

  logic                  cmd_ready;
  logic                  push;
  logic                  pop;

  // Gated by reset so no command can be taken while the block is held in reset.
  assign cmd_ready = hresetn && (count_q != CntFull);
  assign push      = bus.cmd_valid && cmd_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pop         = 1'b0;
    rsp_load    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWaitLo;
      end
      StWaitLo: begin
        // Timeout wins over a coincident hready event.
        if (timer_q == TmrLimit) begin
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end else if (!bus.hready) begin
          state_d = StWaitHi;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWaitHi: begin
        if (timer_q == TmrLimit) begin
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end else if (bus.hready) begin
          rsp_load    = 1'b1;
          rsp_rdata_d = hwrite_q ? '0 : bus.hrdata;
          state_d     = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge hclk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hwrite_q    <= 1'b0;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      rsp_valid_q <= (state_d == StResp);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q                       <= rd_ptr_q + 1'b1;
        {hwrite_q, haddr_q, hwdata_q} <= fifo_mem[rd_ptr_q];
      end
      if (rsp_load) begin
        rsp_write_q <= hwrite_q;
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= rsp_err_d;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.hsel      = (state_q == StIssue);
  assign bus.haddr     = haddr_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hwdata    = hwdata_q;
  assign bus.busy      = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_sram_access_master.sv
// Directed bench for sram_access_master: behavioural downstream model plus per-scenario tasks.
module tb_sram_access_master;
  localparam int unsigned AW    = 4;
  localparam int unsigned WW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 15;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  sram_access_master_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  sram_access_master #(
    .ADDR_WIDTH(AW),
    .WORD_WIDTH(WW),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Downstream model knobs.
  int          dn_wait;
  int          dn_cnt;
  bit          dn_stall;
  bit          dn_stuck;
  bit          dn_map;
  logic [7:0]  dn_rdata;

  logic [9:0]  rsp_q  [$];
  logic [3:0]  hsel_q [$];

  // Mapped read data makes every read result depend on the address it came from.
  assign bus.hrdata = dn_map ? {bus.haddr, ~bus.haddr} : dn_rdata;

  always @(posedge hclk) begin
    if (!hresetn) begin
      bus.hready <= 1'b1;
      dn_cnt     <= 0;
    end else if (bus.hsel && !dn_stuck) begin
      bus.hready <= 1'b0;
      dn_cnt     <= dn_wait;
    end else if (!bus.hready && !dn_stall) begin
      if (dn_cnt <= 1) bus.hready <= 1'b1;
      else             dn_cnt     <= dn_cnt - 1;
    end
  end

  always @(posedge hclk) begin
    if (hresetn && bus.rsp_valid && bus.rsp_ready)
      rsp_q.push_back({bus.rsp_write, bus.rsp_err, bus.rsp_rdata});
    if (hresetn && bus.hsel) hsel_q.push_back(bus.haddr);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic logic [26:0] all_outs();
    all_outs = {bus.cmd_ready, bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.rsp_err,
                bus.hsel, bus.haddr, bus.hwrite, bus.hwdata, bus.busy};
  endfunction

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic push_cmd(input logic w, input logic [3:0] a, input logic [7:0] d,
                          output bit ok);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (bus.cmd_ready === 1'b1) ok = 1'b1;
      step();
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_hsel(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      if (bus.hsel === 1'b1) ok = 1'b1;
      else step();
    end
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = -1;
    for (int i = 0; i < max && n < 0; i++) begin
      if (bus.rsp_valid === 1'b1) n = i;
      else step();
    end
  endtask

  task automatic test_reset();
    step();
    total++;
    if (all_outs() !== '0) begin
      bad++; $display("FAIL reset_outs_1 got=%h want=0", all_outs());
    end
    step();
    total++;
    if (all_outs() !== '0) begin
      bad++; $display("FAIL reset_outs_2 got=%h want=0", all_outs());
    end
    hresetn       = 1'b1;
    bus.cmd_valid = 1'b0;
    #1;
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_no_push busy got=%b want=0", bus.busy);
    end
    step();
  endtask

  task automatic test_single_write();
    bit ok;
    int n;
    dn_wait = 1; dn_map = 1'b1;
    hsel_q.delete();
    push_cmd(1'b1, 4'h3, 8'h5A, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wr_accept got=0 want=1"); end
    total++;
    if (bus.hsel !== 1'b0) begin
      bad++; $display("FAIL wr_hsel_c1 got=%b want=0", bus.hsel);
    end
    step();
    total++;
    if ({bus.hsel, bus.haddr, bus.hwrite, bus.hwdata} !== {1'b1, 4'h3, 1'b1, 8'h5A}) begin
      bad++; $display("FAIL wr_issue got=%b/%h/%b/%h want=1/3/1/5a",
                      bus.hsel, bus.haddr, bus.hwrite, bus.hwdata);
    end
    step();
    wait_rsp(20, n);
    total++;
    if (n !== 2) begin bad++; $display("FAIL wr_latency got=%0d want=3", n + 1); end
    total++;
    if ({bus.rsp_write, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 8'h00}) begin
      bad++; $display("FAIL wr_rsp got=%b/%b/%h want=1/0/00",
                      bus.rsp_write, bus.rsp_err, bus.rsp_rdata);
    end
    total++;
    if ({bus.haddr, bus.hwrite, bus.hwdata} !== {4'h3, 1'b1, 8'h5A}) begin
      bad++; $display("FAIL wr_hold got=%h/%b/%h want=3/1/5a", bus.haddr, bus.hwrite, bus.hwdata);
    end
    step(); step(); step();
    total++;
    if (hsel_q.size() !== 1 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL wr_one_pulse got=%0d/%b want=1/0", hsel_q.size(), bus.rsp_valid);
    end
  endtask

  task automatic test_read();
    bit ok;
    int n;
    dn_wait = 2; dn_map = 1'b0; dn_rdata = 8'hA5;
    push_cmd(1'b0, 4'hC, 8'hFF, ok);
    wait_hsel(10, ok);
    total++;
    if (!ok || bus.haddr !== 4'hC || bus.hwrite !== 1'b0) begin
      bad++; $display("FAIL rd_issue got=%b/%h/%b want=1/c/0", ok, bus.haddr, bus.hwrite);
    end
    wait_rsp(20, n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL rd_latency got=%0d want=4", n); end
    total++;
    if ({bus.rsp_write, bus.rsp_err, bus.rsp_rdata} !== {1'b0, 1'b0, 8'hA5}) begin
      bad++; $display("FAIL rd_rsp got=%b/%b/%h want=0/0/a5",
                      bus.rsp_write, bus.rsp_err, bus.rsp_rdata);
    end
    step();
  endtask

  task automatic test_back_pressure();
    bit ok;
    logic [3:0] addrs [5];
    logic [9:0] exp_rsp [6];
    logic [3:0] exp_sel [6];
    addrs   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF};
    exp_rsp = '{10'h069, 10'h01E, 10'h02D, 10'h04B, 10'h087, 10'h0F0};
    exp_sel = '{4'h6, 4'h1, 4'h2, 4'h4, 4'h8, 4'hF};
    dn_wait = 1; dn_map = 1'b1; dn_stall = 1'b1;
    rsp_q.delete(); hsel_q.delete();
    // A blocker read holds the engine in WAIT_HI while the FIFO fills.
    push_cmd(1'b0, 4'h6, 8'h00, ok);
    wait_hsel(10, ok);
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = addrs[i]; bus.cmd_wdata = 8'h00;
      total++;
      if (bus.cmd_ready !== 1'b1) begin
        bad++; $display("FAIL bp_accept_%0d got=%b want=1", i, bus.cmd_ready);
      end
      step();
    end
    bus.cmd_addr = addrs[4];
    total++;
    if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL bp_full ready/busy got=%b/%b want=0/1", bus.cmd_ready, bus.busy);
    end
    dn_stall = 1'b0;
    push_cmd(1'b0, addrs[4], 8'h00, ok);
    total++;
    if (!ok || rsp_q.size() !== 1) begin
      bad++; $display("FAIL bp_fifth got=%b/%0d want=1/1", ok, rsp_q.size());
    end
    for (int i = 0; i < 200 && rsp_q.size() < 6; i++) step();
    total++;
    if (rsp_q.size() !== 6 || hsel_q.size() !== 6) begin
      bad++; $display("FAIL bp_count got=%0d/%0d want=6/6", rsp_q.size(), hsel_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (rsp_q[i] !== exp_rsp[i] || hsel_q[i] !== exp_sel[i]) begin
          bad++; $display("FAIL bp_order_%0d got=%h/%h want=%h/%h",
                          i, rsp_q[i], hsel_q[i], exp_rsp[i], exp_sel[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    dn_stuck = 1'b1; dn_map = 1'b1; dn_wait = 1;
    push_cmd(1'b0, 4'h9, 8'h00, ok);
    wait_hsel(10, ok);
    wait_rsp(40, n);
    total++;
    if (n !== TMO + 2) begin bad++; $display("FAIL to_latency got=%0d want=%0d", n, TMO + 2); end
    total++;
    if ({bus.rsp_write, bus.rsp_err, bus.rsp_rdata} !== {1'b0, 1'b1, 8'h00}) begin
      bad++; $display("FAIL to_rsp got=%b/%b/%h want=0/1/00",
                      bus.rsp_write, bus.rsp_err, bus.rsp_rdata);
    end
    step();
    dn_stuck = 1'b0;
    push_cmd(1'b1, 4'h7, 8'h3C, ok);
    wait_hsel(10, ok);
    total++;
    if (!ok || {bus.haddr, bus.hwdata} !== {4'h7, 8'h3C}) begin
      bad++; $display("FAIL to_next_issue got=%b/%h/%h want=1/7/3c", ok, bus.haddr, bus.hwdata);
    end
    wait_rsp(20, n);
    total++;
    if (n !== 3 || {bus.rsp_write, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 8'h00}) begin
      bad++; $display("FAIL to_next_rsp got=%0d/%b/%b/%h want=3/1/0/00",
                      n, bus.rsp_write, bus.rsp_err, bus.rsp_rdata);
    end
    step();
  endtask

  task automatic test_stall_reset();
    bit ok;
    bit seen;
    int n;
    dn_wait = 1; dn_map = 1'b1;
    bus.rsp_ready = 1'b0;
    push_cmd(1'b0, 4'h5, 8'h00, ok);
    push_cmd(1'b0, 4'hA, 8'h00, ok);
    wait_rsp(20, n);
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({bus.rsp_valid, bus.rsp_write, bus.rsp_err, bus.rsp_rdata, bus.hsel} !==
          {1'b1, 1'b0, 1'b0, 8'h5A, 1'b0}) begin
        bad++; $display("FAIL stall_hold_%0d got=%b/%b/%b/%h/%b want=1/0/0/5a/0", i,
                        bus.rsp_valid, bus.rsp_write, bus.rsp_err, bus.rsp_rdata, bus.hsel);
      end
      step();
    end
    push_cmd(1'b1, 4'hD, 8'h77, ok);
    dn_stall = 1'b1;
    bus.rsp_ready = 1'b1;
    step();
    wait_hsel(10, ok);
    total++;
    if (!ok || bus.haddr !== 4'hA) begin
      bad++; $display("FAIL stall_second_issue got=%b/%h want=1/a", ok, bus.haddr);
    end
    step(); step();
    total++;
    if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL stall_wait_hi got=%b/%b want=1/0", bus.busy, bus.rsp_valid);
    end
    hresetn = 1'b0;
    step();
    total++;
    if (all_outs() !== '0) begin
      bad++; $display("FAIL midreset_outs got=%h want=0", all_outs());
    end
    hresetn  = 1'b1;
    dn_stall = 1'b0;
    #1;
    total++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL midreset_empty got=%b/%b want=1/0", bus.cmd_ready, bus.busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.rsp_valid !== 1'b0 || bus.hsel !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL midreset_quiet got=1 want=0"); end
  endtask

  initial begin
    hresetn       = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 4'h5;
    bus.cmd_wdata = 8'h11;
    bus.rsp_ready = 1'b1;
    dn_wait  = 1;
    dn_stall = 1'b0;
    dn_stuck = 1'b0;
    dn_map   = 1'b0;
    dn_rdata = 8'h00;

    test_reset();
    test_single_write();
    test_read();
    test_back_pressure();
    test_timeout();
    test_stall_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
